dqs_rd_bitslip_train: RTL
=========================

// Module: dqs_rd_bitslip_train
// PURPOSE
//  Read-side DQS word-alignment trainer; sits downstream of the 8:1 DQS input
//  deserializer and consumes its q1..q8 parallel word on the gsclk_il domain.
//  During a training read burst it compares the word against the expected
//  toggle pattern and issues single-cycle bitslip pulses to the deserializer's
//  align_0_il input until the word is aligned, then reports done/fail.
// PARAMETERS
//  EXP_PAT     8'h55  expected aligned word {q8..q1} while DQS toggles
//  MATCH_CNT   16     consecutive matching rd_valid cycles required to lock (1..255)
//  SETTLE_CYC  8      gsclk cycles ignored after each slip pulse (1..255)
//  MAX_SLIP    7      maximum slips before declaring failure (0..7)
//  TIMEOUT     1023   gsclk cycles in SAMPLE without any rd_valid before fail (1..65535)
// PORTS
//  gsclk_il     in   1  slow system clock of the input deserializer; all logic on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  q            in   8  deserialized DQS word, q[0]=q1 .. q[7]=q8
//  rd_valid     in   1  high while q carries a training read burst
//  train_start  in   1  one-cycle request to (re)start training
//  align_pulse  out  1  one-cycle bitslip request, wired to align_0_il
//  train_busy   out  1  high from accepted start until done/fail
//  train_done   out  1  sticky lock flag, cleared by next accepted start
//  train_fail   out  1  sticky failure flag, cleared by next accepted start
//  slip_cnt     out  3  number of slips issued in current/last run
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; match/settle/timeout counters 0.
//  - All outputs registered; align_pulse asserted exactly one cycle per slip.
//  - States: IDLE, SAMPLE, SLIP, SETTLE, DONE, FAIL.
//  - IDLE/DONE/FAIL + train_start -> SAMPLE next cycle: clear done/fail,
//    slip_cnt:=0, match:=0, tmo:=0, busy:=1. train_start in other states ignored.
//  - SAMPLE, rd_valid=1, q==EXP_PAT: match+1, tmo:=0; when match+1==MATCH_CNT
//    -> DONE (done:=1, busy:=0).
//  - SAMPLE, rd_valid=1, q!=EXP_PAT: match:=0, tmo:=0; if slip_cnt==MAX_SLIP
//    -> FAIL (fail:=1, busy:=0) else -> SLIP.
//  - SAMPLE, rd_valid=0: match held (gaps between bursts allowed), tmo+1;
//    tmo reaching TIMEOUT -> FAIL.
//  - SLIP: align_pulse=1 for this one cycle, slip_cnt+1 -> SETTLE, settle:=0.
//  - SETTLE: q/rd_valid ignored; after SETTLE_CYC cycles -> SAMPLE, match:=0.
//  - slip_cnt never wraps (bounded by MAX_SLIP<=7).
//  - Match and mismatch decided only on the same cycle rd_valid is high; no
//    pipelining of q, so decision latency is 1 cycle from sample to state.
//  - rst_n asserted mid-run: immediate return to reset values; an in-flight
//    align_pulse is dropped.
//  - done and fail mutually exclusive; DONE/FAIL hold until a new start.
// STRUCTURE
//  - Package dqs_train_pkg: state enum (3-bit encoding), GEAR_W=8,
//    SLIP_W=3, default EXP_PAT constant; shared with the write-leveling trainer.
//  - One sub-module: dqs_train_timer (loadable up-counter with terminal flag),
//    instanced for settle and timeout counting; FSM and match counter inline.
// TESTING
//  - Aligned: start, rd_valid=1, q=8'h55 for 16 cycles -> done=1 at cycle 17,
//    slip_cnt=0, no align_pulse.
//  - Two slips: q=8'hAA until 2nd SETTLE ends, then 8'h55 -> exactly 2
//    align_pulse each 1 cycle wide, spaced >=10 cycles, done=1, slip_cnt=2.
//  - Never aligns: q=8'h00 continuously -> 7 pulses, then fail=1, slip_cnt=7,
//    busy=0, no 8th pulse.
//  - Timeout: start with rd_valid=0 for 1023 cycles -> fail=1, slip_cnt=0.
//  - Gapped burst: 10 matches, rd_valid=0 for 50 cycles, 6 matches -> done=1.
//  - Reset mid-SLIP: drop rst_n on align_pulse cycle -> pulse low same cycle
//    (async), all outputs 0; start after release retrains from slip_cnt=0.

Source files
------------

// File: rtl/dqs_train_pkg.sv
// Shared types and constants for the DQS read/write training blocks.
package dqs_train_pkg;

   localparam int unsigned GEAR_W = 8;
   localparam int unsigned SLIP_W = 3;

   localparam logic [GEAR_W-1:0] EXP_PAT_DEF = 8'h55;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_SLIP   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4,
      ST_FAIL   = 3'd5
   } train_state_t;

endpackage

// File: rtl/dqs_train_timer.sv
// Clearable up-counter with a terminal flag that fires on the increment
// that brings the count to TERM. Saturates at all-ones so it never wraps.
module dqs_train_timer #(
   parameter int unsigned W    = 8,
   parameter int unsigned TERM = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic term_c
);

   logic [W-1:0] cnt;

   // Count register: clear has priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

   // Terminal flag: this increment completes TERM counts.
   assign term_c = inc && !clr && (cnt == W'(TERM - 1));

endmodule

// File: rtl/dqs_rd_bitslip_train.sv
// Read-side DQS word-alignment trainer: compares the deserialized word with
// the expected toggle pattern during a training burst and issues bitslip
// pulses until the word is aligned, then reports done or fail.
module dqs_rd_bitslip_train
   import dqs_train_pkg::*;
#(
   parameter logic [GEAR_W-1:0] EXP_PAT    = EXP_PAT_DEF,
   parameter int unsigned       MATCH_CNT  = 16,
   parameter int unsigned       SETTLE_CYC = 8,
   parameter int unsigned       MAX_SLIP   = 7,
   parameter int unsigned       TIMEOUT    = 1023
) (
   input  logic              gsclk_il,
   input  logic              rst_n,
   input  logic [GEAR_W-1:0] q,
   input  logic              rd_valid,
   input  logic              train_start,
   output logic              align_pulse,
   output logic              train_busy,
   output logic              train_done,
   output logic              train_fail,
   output logic [SLIP_W-1:0] slip_cnt
);

   localparam int unsigned MATCH_W  = 8;
   localparam int unsigned SETTLE_W = 8;
   localparam int unsigned TMO_W    = 16;

   train_state_t       state;
   logic [MATCH_W-1:0] match_cnt;

   logic settle_clr_c;
   logic settle_inc_c;
   logic settle_term_c;
   logic tmo_clr_c;
   logic tmo_inc_c;
   logic tmo_term_c;

   // Timer controls: each timer only runs in its own state and is held at zero otherwise.
   assign settle_clr_c = (state != ST_SETTLE);
   assign settle_inc_c = (state == ST_SETTLE);
   assign tmo_clr_c    = (state != ST_SAMPLE) || rd_valid;
   assign tmo_inc_c    = (state == ST_SAMPLE) && !rd_valid;

   dqs_train_timer #(
      .W    (SETTLE_W),
      .TERM (SETTLE_CYC)
   ) u_settle_timer (
      .clk    (gsclk_il),
      .rst_n  (rst_n),
      .clr    (settle_clr_c),
      .inc    (settle_inc_c),
      .term_c (settle_term_c)
   );

   dqs_train_timer #(
      .W    (TMO_W),
      .TERM (TIMEOUT)
   ) u_tmo_timer (
      .clk    (gsclk_il),
      .rst_n  (rst_n),
      .clr    (tmo_clr_c),
      .inc    (tmo_inc_c),
      .term_c (tmo_term_c)
   );

   // Training FSM with registered outputs; align_pulse is raised on entry to SLIP only.
   always_ff @(posedge gsclk_il or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         align_pulse <= 1'b0;
         train_busy  <= 1'b0;
         train_done  <= 1'b0;
         train_fail  <= 1'b0;
         slip_cnt    <= '0;
         match_cnt   <= '0;
      end else begin
         align_pulse <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (train_start) begin
                  state      <= ST_SAMPLE;
                  train_busy <= 1'b1;
                  train_done <= 1'b0;
                  train_fail <= 1'b0;
                  slip_cnt   <= '0;
                  match_cnt  <= '0;
               end
            end
            ST_SAMPLE: begin
               if (rd_valid) begin
                  if (q == EXP_PAT) begin
                     match_cnt <= match_cnt + MATCH_W'(1);
                     if (match_cnt == MATCH_W'(MATCH_CNT - 1)) begin
                        state      <= ST_DONE;
                        train_done <= 1'b1;
                        train_busy <= 1'b0;
                     end
                  end else begin
                     match_cnt <= '0;
                     if (slip_cnt == SLIP_W'(MAX_SLIP)) begin
                        state      <= ST_FAIL;
                        train_fail <= 1'b1;
                        train_busy <= 1'b0;
                     end else begin
                        state       <= ST_SLIP;
                        align_pulse <= 1'b1;
                     end
                  end
               end else if (tmo_term_c) begin
                  state      <= ST_FAIL;
                  train_fail <= 1'b1;
                  train_busy <= 1'b0;
               end
            end
            ST_SLIP: begin
               slip_cnt <= slip_cnt + SLIP_W'(1);
               state    <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_term_c) begin
                  state     <= ST_SAMPLE;
                  match_cnt <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
